// File: rtl/xor_slice_sequencer.sv
// rtl/xor_slice_sequencer.sv - round-robin sequencer sharing one narrow XOR slice between two requesters
module xor_slice_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic [SLICE_W-1:0] slice_in1,
  output logic [SLICE_W-1:0] slice_in2,
  input  logic [SLICE_W-1:0] slice_out,
  output logic              slice_en,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_id,
  output logic              busy
);

  localparam int NSL   = DATA_W / SLICE_W;
  localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              id_q, id_d;
  logic              last_grant_q, last_grant_d;
  logic              grant;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end else if (req_valid[1]) begin
      grant = 1'b1;
    end
  end

  // Next-state, lane steering and result assembly.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    req_ready    = 2'b00;
    slice_in1    = '0;
    slice_in2    = '0;
    slice_en     = 1'b0;
    resp_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid[grant]) begin
          // Operands are captured only here; later input changes are ignored.
          req_ready[grant] = 1'b1;
          a_d          = grant ? req_a1 : req_a0;
          b_d          = grant ? req_b1 : req_b0;
          id_d         = grant;
          last_grant_d = grant;
          cnt_d        = '0;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        slice_en = 1'b1;
        for (int i = 0; i < NSL; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            slice_in1 = a_q[i*SLICE_W +: SLICE_W];
            slice_in2 = b_q[i*SLICE_W +: SLICE_W];
            res_d[i*SLICE_W +: SLICE_W] = slice_out;
          end
        end
        if (cnt_q == CNT_W'(NSL - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign resp_data = res_q;
  assign resp_id   = id_q;

endmodule

// File: tb/tb_xor_slice_sequencer.sv
// tb/tb_xor_slice_sequencer.sv - directed table-driven bench for xor_slice_sequencer
module tb_xor_slice_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [7:0]  slice_in1, slice_in2, slice_out;
  logic        slice_en;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;
  logic        busy;

  int n_cmp;
  int n_err;

  xor_slice_sequencer #(.DATA_W(32), .SLICE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .slice_in1 (slice_in1),
    .slice_in2 (slice_in2),
    .slice_out (slice_out),
    .slice_en  (slice_en),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_id   (resp_id),
    .busy      (busy)
  );

  // External shared slice: plain combinational XOR.
  assign slice_out = slice_in1 ^ slice_in2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        id;
    logic [31:0] data;
    int          hold;
    bit          mut;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at negedge+1; returns at negedge+1 with the DUT back in IDLE.
  task automatic do_op(input vec_t v);
    logic [31:0] la, lb;
    logic [1:0]  exp_rdy;
    la = v.id ? v.a1 : v.a0;
    lb = v.id ? v.b1 : v.b0;
    exp_rdy = v.id ? 2'b10 : 2'b01;
    req_valid  = v.valid;
    req_a0     = v.a0;
    req_b0     = v.b0;
    req_a1     = v.a1;
    req_b1     = v.b1;
    resp_ready = (v.hold == 0);
    #1;
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("req_ready_grant", {30'b0, req_ready}, {30'b0, exp_rdy});
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0 && v.mut) begin
        req_a0 = 32'h12345678;
        req_b0 = ~v.b0;
        req_a1 = ~v.a1;
      end
      #1;
      check("run_slice_en", {31'b0, slice_en}, 32'd1);
      check("run_slice_in1", {24'b0, slice_in1}, {24'b0, la[k*8 +: 8]});
      check("run_slice_in2", {24'b0, slice_in2}, {24'b0, lb[k*8 +: 8]});
      check("run_req_ready", {30'b0, req_ready}, 32'd0);
      check("run_resp_valid", {31'b0, resp_valid}, 32'd0);
    end
    @(negedge clk);
    #1;
    check("done_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("done_resp_data", resp_data, v.data);
    check("done_resp_id", {31'b0, resp_id}, {31'b0, v.id});
    check("done_slice_en", {31'b0, slice_en}, 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      #1;
      check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_resp_data", resp_data, v.data);
      check("bp_resp_id", {31'b0, resp_id}, {31'b0, v.id});
      check("bp_req_ready", {30'b0, req_ready}, 32'd0);
      check("bp_slice_en", {31'b0, slice_en}, 32'd0);
      check("bp_busy", {31'b0, busy}, 32'd1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("back_idle_busy", {31'b0, busy}, 32'd0);
    check("back_idle_resp_valid", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    vec_t v;
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{2'b01, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 32'h0, 1'b0, 32'hF0F00F0F, 0, 1'b1};
    vecs[1] = '{2'b11, 32'h12345678, 32'hFFFFFFFF, 32'hAAAA5555, 32'h00FF00FF, 1'b1, 32'hAA5555AA, 0, 1'b0};
    vecs[2] = '{2'b11, 32'h12345678, 32'hFFFFFFFF, 32'hAAAA5555, 32'h00FF00FF, 1'b0, 32'hEDCBA987, 10, 1'b0};
    vecs[3] = '{2'b11, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h00000000, 0, 1'b0};
    vecs[4] = '{2'b10, 32'h00000000, 32'h00000000, 32'h01234567, 32'h89ABCDEF, 1'b1, 32'h88888888, 0, 1'b0};
    vecs[5] = '{2'b11, 32'h80000001, 32'h00000001, 32'h11111111, 32'h22222222, 1'b0, 32'h80000000, 0, 1'b0};

    rst_n = 1'b0;
    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_slice_en", {31'b0, slice_en}, 32'd0);
    check("rst_req_ready", {30'b0, req_ready}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", {31'b0, resp_id}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i]);
    end

    // Idle-gap fairness: requester 1 alone, three idle cycles, then contention.
    v = '{2'b10, 32'h0, 32'h0, 32'hCAFEF00D, 32'hFFFF0000, 1'b1, 32'h3501F00D, 0, 1'b0};
    do_op(v);
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("gap_req_ready", {30'b0, req_ready}, 32'd0);
      check("gap_busy", {31'b0, busy}, 32'd0);
    end
    v = '{2'b11, 32'h0000FFFF, 32'h00FF00FF, 32'h55555555, 32'h0, 1'b0, 32'h00FFFF00, 0, 1'b0};
    do_op(v);

    // Reset in the middle of RUN with the lane counter at 2.
    req_valid = 2'b01;
    req_a0 = 32'hA1B2C3D4;
    req_b0 = 32'h0;
    resp_ready = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    #1;
    check("mid_lane2", {24'b0, slice_in1}, 32'h000000B2);
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_slice_en", {31'b0, slice_en}, 32'd0);
    check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    v = '{2'b11, 32'h0F0F0F0F, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0F0F0F0F, 0, 1'b0};
    do_op(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
